// File: rtl/amem_pass.sv
// A-memory array with a one-entry write buffer and read pass-around.
//
// Sits downstream of the A-control stage. Writes are captured into a
// one-entry buffer and committed to the array on the following cycle through
// the array's dedicated write port. Reads that hit the buffered address are
// served from the buffer, so a read always observes the most recent write
// issued before its own cycle. After reset a sweep clears every location
// before any access is accepted.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   aadr   - access address (read address for arp, write address for awp)
//   arp    - read strobe
//   awp    - write strobe
//   l      - write data
//   a      - registered read data
//   apass  - last read was served from the write buffer
//   busy   - clear sweep in progress; arp/awp ignored
module amem_pass #(
  parameter int unsigned    AW        = 10,
  parameter int unsigned    DW        = 32,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] aadr,
  input  logic          arp,
  input  logic          awp,
  input  logic [DW-1:0] l,
  output logic [DW-1:0] a,
  output logic          apass,
  output logic          busy
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          wb_v_q, wb_v_d;
  logic [AW-1:0] wb_adr_q, wb_adr_d;
  logic [DW-1:0] wb_dat_q, wb_dat_d;

  logic [DW-1:0] a_q, a_d;
  logic          apass_q, apass_d;

  logic [DW-1:0] mem [Depth];

  // Single write port shared by the clear sweep and the buffer commit.
  logic          mem_we;
  logic [AW-1:0] mem_wadr;
  logic [DW-1:0] mem_wdat;

  logic          rd_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_v_d   = wb_v_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    a_d      = a_q;
    apass_d  = apass_q;
    mem_we   = 1'b0;
    mem_wadr = cnt_q;
    mem_wdat = CLEAR_VAL;
    rd_hit   = 1'b0;

    unique case (state_q)
      StClear: begin
        mem_we   = 1'b1;
        mem_wadr = cnt_q;
        mem_wdat = CLEAR_VAL;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A valid entry always commits the cycle after it was loaded; a new
        // awp reloads the buffer in that same cycle, so nothing is lost.
        mem_we   = wb_v_q;
        mem_wadr = wb_adr_q;
        mem_wdat = wb_dat_q;
        wb_v_d   = awp;
        if (awp) begin
          wb_adr_d = aadr;
          wb_dat_d = l;
        end
        // Compare against the buffer contents at the start of the cycle, so
        // a simultaneous awp is not passed (read-before-write).
        if (arp) begin
          rd_hit  = wb_v_q && (wb_adr_q == aadr);
          a_d     = rd_hit ? wb_dat_q : mem[aadr];
          apass_d = rd_hit;
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      wb_v_q   <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      a_q      <= '0;
      apass_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_v_q   <= wb_v_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      a_q      <= a_d;
      apass_q  <= apass_d;
    end
  end

  // A pending buffer entry is discarded on reset rather than committed.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_wadr] <= mem_wdat;
    end
  end

  assign a     = a_q;
  assign apass = apass_q;
  assign busy  = (state_q == StClear);

endmodule

// File: tb/tb_amem_pass.sv
// Randomized self-checking bench for amem_pass against a behavioural model:
// the model keeps a plain shadow array of the latest written values, a count
// of sweep cycles remaining, and the previous cycle's write (which is what a
// pass-around read hits).
module tb_amem_pass;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned Depth = 1 << AW;

  logic          clk;
  logic          reset;
  logic [AW-1:0] aadr;
  logic          arp;
  logic          awp;
  logic [DW-1:0] l;
  logic [DW-1:0] a;
  logic          apass;
  logic          busy;

  amem_pass #(
    .AW        (AW),
    .DW        (DW),
    .CLEAR_VAL ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .aadr  (aadr),
    .arp   (arp),
    .awp   (awp),
    .l     (l),
    .a     (a),
    .apass (apass),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [DW-1:0] shadow [Depth];
  int            clr_left;
  logic          prev_wp;
  logic [AW-1:0] prev_adr;
  logic [DW-1:0] exp_a;
  logic          exp_apass;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) shadow[i] = '0;
    clr_left  = Depth;
    prev_wp   = 1'b0;
    prev_adr  = '0;
    exp_a     = '0;
    exp_apass = 1'b0;
  endtask

  // Hold reset for n edges with garbage on the inputs, then release.
  task automatic do_reset(input int n);
    reset = 1'b1;
    arp   = 1'($urandom);
    awp   = 1'($urandom);
    aadr  = AW'($urandom);
    l     = $urandom;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    check("rst_a", a, exp_a);
    check("rst_apass", {31'b0, apass}, {31'b0, exp_apass});
    check("rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    arp   = 1'b0;
    awp   = 1'b0;
  endtask

  // One clock cycle of stimulus, followed by a check of all outputs.
  task automatic step(input logic [AW-1:0] adr, input logic rp, input logic wp,
                      input logic [DW-1:0] dat);
    aadr = adr;
    arp  = rp;
    awp  = wp;
    l    = dat;
    if (clr_left > 0) begin
      clr_left--;
      prev_wp = 1'b0;
    end else begin
      if (rp) begin
        exp_a     = shadow[adr];
        exp_apass = prev_wp && (prev_adr == adr);
      end
      if (wp) shadow[adr] = dat;
      prev_wp  = wp;
      prev_adr = adr;
    end
    @(posedge clk);
    #1;
    check("busy", {31'b0, busy}, {31'b0, (clr_left > 0)});
    check("a", a, exp_a);
    check("apass", {31'b0, apass}, {31'b0, exp_apass});
    arp = 1'b0;
    awp = 1'b0;
  endtask

  // Sweep with random strobes, which must all be ignored.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      step(AW'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1;
    arp   = 1'b0;
    awp   = 1'b0;
    aadr  = '0;
    l     = '0;

    do_reset(3);
    sweep(Depth);
    check("sweep_done", {31'b0, busy}, 32'd0);

    // Never-written top address reads as the clear value.
    step(10'h3FF, 1'b1, 1'b0, '0);
    check("rd_3ff", a, 32'h0);
    check("rd_3ff_pass", {31'b0, apass}, 32'd0);

    // Write, let it commit, read back from the array.
    step(10'h012, 1'b0, 1'b1, 32'hDEADBEEF);
    idle();
    idle();
    step(10'h012, 1'b1, 1'b0, '0);
    check("sep_a", a, 32'hDEADBEEF);
    check("sep_pass", {31'b0, apass}, 32'd0);

    // Pass-around on the cycle right after the write.
    step(10'h055, 1'b0, 1'b1, 32'h12345678);
    step(10'h055, 1'b1, 1'b0, '0);
    check("pass_a", a, 32'h12345678);
    check("pass_flag", {31'b0, apass}, 32'd1);
    step(10'h055, 1'b0, 1'b1, 32'h12345678);
    step(10'h056, 1'b1, 1'b0, '0);
    check("nopass_a", a, 32'h0);
    check("nopass_flag", {31'b0, apass}, 32'd0);

    // Back-to-back writes both land.
    step(10'h001, 1'b0, 1'b1, 32'hA);
    step(10'h002, 1'b0, 1'b1, 32'hB);
    idle();
    step(10'h001, 1'b1, 1'b0, '0);
    check("b2b_1", a, 32'hA);
    step(10'h002, 1'b1, 1'b0, '0);
    check("b2b_2", a, 32'hB);
    check("b2b_2_pass", {31'b0, apass}, 32'd0);

    // Simultaneous read and write: read-before-write, then pass next cycle.
    step(10'h020, 1'b0, 1'b1, 32'h1111);
    idle();
    idle();
    step(10'h020, 1'b1, 1'b1, 32'h2222);
    check("rw_old", a, 32'h1111);
    check("rw_old_pass", {31'b0, apass}, 32'd0);
    step(10'h020, 1'b1, 1'b0, '0);
    check("rw_new", a, 32'h2222);
    check("rw_new_pass", {31'b0, apass}, 32'd1);

    // Random traffic over a small address set to provoke hits.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 7));
      step(ra, 1'($urandom), 1'($urandom), $urandom);
    end

    // Reset mid-sweep restarts the full sweep.
    do_reset(2);
    sweep(500);
    do_reset(1);
    sweep(Depth);
    check("resweep_done", {31'b0, busy}, 32'd0);

    // A write still in the buffer when reset hits is discarded.
    step(10'h030, 1'b0, 1'b1, 32'h77);
    do_reset(1);
    sweep(Depth);
    step(10'h030, 1'b1, 1'b0, '0);
    check("rst_discard", a, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
